// File: rtl/cr_kme_int_event_log.sv
`default_nettype none
// ============================================================================
// Module   : cr_kme_int_event_log
// Brief    : Latches KME event pulses as pending, round-robin arbitrates them
//            into a {source id, timestamp} log FIFO popped by firmware.
// Revision : 1.0 - initial release
// ============================================================================
module cr_kme_int_event_log #(
  parameter int N_SRC = 16,
  parameter int SRC_W = 4,
  parameter int DEPTH = 8,
  parameter int TS_W  = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_SRC-1:0]             event_in,
  input  logic                         pop,
  input  logic                         clear,
  output logic                         log_valid,
  output logic [SRC_W-1:0]             log_src_id,
  output logic [TS_W-1:0]              log_timestamp,
  output logic [$clog2(DEPTH+1)-1:0]   log_count,
  output logic [7:0]                   coalesce_cnt
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_PW = c_AW + 1;
  localparam int c_MW = $clog2(N_SRC + 1);

  logic [TS_W-1:0]  r_ts;
  logic [N_SRC-1:0] r_pending;
  logic [SRC_W-1:0] r_rr_last;
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [7:0]       r_coal;
  logic [SRC_W-1:0] r_mem_src [DEPTH];
  logic [TS_W-1:0]  r_mem_ts  [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_grant_en;
  logic             w_pop;
  logic             w_grant_vld;
  logic [SRC_W-1:0] w_grant_idx;
  logic [N_SRC-1:0] w_grant;
  logic [N_SRC-1:0] w_merge;
  logic [c_MW-1:0]  w_merge_cnt;
  logic [31:0]      w_coal_sum;
  logic [7:0]       w_coal_next;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_grant_en = (|r_pending) & ~w_full & ~clear;
  assign w_pop      = pop & ~w_empty & ~clear;

  // Round robin: lowest pending index above rr_last wins, else lowest overall.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_grant_en && r_pending[i] && (SRC_W'(i) > r_rr_last)) begin
        w_grant_vld = 1'b1;
        w_grant_idx = SRC_W'(i);
      end
    end
    if (!w_grant_vld) begin
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (w_grant_en && r_pending[i] && (SRC_W'(i) <= r_rr_last)) begin
          w_grant_vld = 1'b1;
          w_grant_idx = SRC_W'(i);
        end
      end
    end
  end

  assign w_grant = w_grant_vld ? (N_SRC'(1) << w_grant_idx) : '0;
  assign w_merge = event_in & r_pending & ~w_grant;

  always_comb begin
    w_merge_cnt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_merge_cnt = w_merge_cnt + c_MW'(w_merge[i]);
    end
  end

  assign w_coal_sum  = 32'(r_coal) + 32'(w_merge_cnt);
  assign w_coal_next = (w_coal_sum > 32'd255) ? 8'hFF : w_coal_sum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts      <= '0;
      r_pending <= '0;
      r_rr_last <= SRC_W'(N_SRC - 1);
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_coal    <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (clear) begin
        r_pending <= '0;
        r_rr_last <= SRC_W'(N_SRC - 1);
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_coal    <= '0;
      end else begin
        r_pending <= event_in | (r_pending & ~w_grant);
        r_coal    <= w_coal_next;
        if (w_grant_vld) begin
          r_rr_last <= w_grant_idx;
          r_wr_ptr  <= r_wr_ptr + c_PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PW'(1);
        end
      end
    end
  end

  // Storage needs no reset: reads are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_grant_vld) begin
      r_mem_src[r_wr_ptr[c_AW-1:0]] <= w_grant_idx;
      r_mem_ts[r_wr_ptr[c_AW-1:0]]  <= r_ts;
    end
  end

  assign log_valid     = ~w_empty;
  assign log_src_id    = w_empty ? '0 : r_mem_src[r_rd_ptr[c_AW-1:0]];
  assign log_timestamp = w_empty ? '0 : r_mem_ts[r_rd_ptr[c_AW-1:0]];
  assign log_count     = r_wr_ptr - r_rd_ptr;
  assign coalesce_cnt  = r_coal;

endmodule
`default_nettype wire

// File: doc/cr_kme_int_event_log.md
Name: cr_kme_int_event_log

Overview:
- Capture, order and buffer individual KME error/interrupt events for firmware.
- Up to N_SRC single-cycle event pulses, including the per-memory MBE strobes, DRBG expiry, TXC backpressure, GCM tag fail and TLV miscompare, are latched as pending.
- A round-robin arbiter grants one pending source per cycle into a small log FIFO of {source id, timestamp} entries.
- Firmware pops entries through the register block. This complements the sticky status bits with per-event ordering and timing.

Parameters:
- N_SRC, 16, number of event sources.
- SRC_W, 4, source id width; must satisfy 2**SRC_W >= N_SRC.
- DEPTH, 8, log FIFO entries; power of two, at least 2.
- TS_W, 24, timestamp counter width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- event_in  in  N_SRC  single-cycle event pulses, one bit per source.
- pop  in  1  register-read strobe; removes the head entry.
- clear  in  1  flush strobe from a register write.
- log_valid  out  1  head entry valid (FIFO non-empty).
- log_src_id  out  SRC_W  head entry source id.
- log_timestamp  out  TS_W  head entry timestamp.
- log_count  out  $clog2(DEPTH+1)  number of entries in the FIFO.
- coalesce_cnt  out  8  events merged into an already-pending source; saturating.

Behaviour:
- Reset (async, rst_n low) clears:
  - all outputs to 0
  - pending, FIFO pointers and timestamp counter to 0
  - rr_last to N_SRC-1, so source 0 has first priority.
- Timestamp counter ts:
  - increments every cycle;
  - wraps from 2**TS_W-1 to 0 with no flag;
  - is not affected by clear.
- Pending update, per bit each cycle: pending_next[i] = event_in[i] | (pending[i] & ~grant[i]).
  - An event arriving on the same cycle its source is granted re-sets pending, so no event is lost.
- Coalescing: coalesce_cnt increments by popcount of (event_in & pending & ~grant).
  - Saturates at 255.
  - Cleared only by clear or reset.
- Arbiter (combinational from registered pending):
  - grant_en = |pending & ~full & ~clear.
  - Picks the first set pending bit searching upward from rr_last+1, modulo N_SRC.
  - grant is one-hot or zero.
  - On grant, rr_last <= granted index.
- FIFO write on grant: entry = {granted index, ts of the grant cycle}.
- Latency:
  - event_in at cycle t sets pending at edge t+1;
  - grant and write occur in cycle t+1;
  - log_valid is high from cycle t+2 when the FIFO was previously empty.
- Full: no grant while log_count == DEPTH, even if pop is asserted that cycle. Pending bits hold and are granted after space frees.
- Empty: pop with log_valid low is ignored; pointers and count are unchanged.
- Head outputs: show-ahead.
  - log_src_id and log_timestamp reflect the head entry whenever log_valid is high.
  - Both are 0 when the FIFO is empty.
- Simultaneous pop and grant while non-empty and not full: log_count is unchanged and both pointers advance.
- Clear has the highest priority. In the clear cycle:
  - the FIFO empties;
  - pending, coalesce_cnt and rr_last are reset;
  - event_in and pop in that cycle are dropped;
  - no grant occurs.
- Pointers are log2(DEPTH) bits with an extra wrap bit. Full and empty are derived from pointer compare, and log_count = wr_ptr - rd_ptr.

Test Plan:
- Single event: after reset, pulse event_in[5] at cycle 10 -> log_valid=1 at cycle 12, log_src_id=5, log_timestamp=11, log_count=1. Then pop -> log_valid=0, log_count=0.
- Round robin: pulse event_in=16'h8421 in one cycle -> entries logged in order 0, 5, 10, 15 on consecutive cycles with timestamps T, T+1, T+2, T+3. Next pulse of 16'h0021 -> order 0, 5 (rr_last=15 wraps to 0).
- Full and backpressure: DEPTH=8, log 8 events, then pulse event_in[3] -> log_count stays 8 and pending[3] holds. One pop -> src 3 is logged on the following cycle and log_count returns to 8.
- Coalescing: while FIFO full, pulse event_in[2] three times -> coalesce_cnt=2 and exactly one src-2 entry is logged after a pop. 300 such merges -> coalesce_cnt=255.
- Simultaneous edges:
  - event_in[7] in the same cycle src 7 is granted -> a second src-7 entry follows;
  - pop on empty -> no change;
  - clear together with event_in and pop -> log_count=0, coalesce_cnt=0, nothing logged afterwards.
- Async reset mid-operation: rst_n low with 4 entries and pending bits set -> all outputs 0 immediately. After release, source 0 has priority and ts restarts at 0.
